// File: rtl/ft_tx_streamer_if.sv
// -----------------------------------------------------------------------------
// ft_tx_streamer_if
// User-side valid/ready stream carrying 16-bit words toward the FT600 TX path.
//   s_data  : user word
//   s_be    : byte enables (2'b11 full word, 2'b01 low byte only)
//   s_valid : word valid (driven by the producer)
//   s_ready : streamer can accept a word (driven by the streamer)
// Modports:
//   master : producer side (application logic / testbench)
//   slave  : consumer side (ft_tx_streamer)
// -----------------------------------------------------------------------------
interface ft_tx_streamer_if;
  logic [15:0] s_data;
  logic [1:0]  s_be;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_be,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_be,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/ft_tx_streamer.sv
// -----------------------------------------------------------------------------
// ft_tx_streamer
// Transmit-direction FT600 245-synchronous-FIFO master. User words enter a
// small circular FIFO through a valid/ready stream and are written to the
// FT600 one word per clock while ft_txe_n is low. A word whose strobe is not
// taken (ft_txe_n high at the edge) is parked on the pins until the FT600 has
// room again, so no word is ever dropped or duplicated.
//
// Parameters:
//   DEPTH_LOG2 : log2 of FIFO depth (legal range 2..8)
//   CNT_W      : width of the transferred-word counter
// Ports:
//   ft_clk      in   FT600 clock, the only clock
//   rst         in   synchronous active-high reset
//   s_if        slave stream: s_data/s_be/s_valid in, s_ready out
//   ft_txe_n    in   FT600 TX FIFO has space when low
//   ft_data     out  write data to pad (registered)
//   ft_be       out  byte enables to pad (registered)
//   ft_data_oe  out  high while the FPGA drives ft_data/ft_be (registered)
//   ft_wr_n     out  write strobe, active low (registered)
//   ft_rd_n     out  held high (registered)
//   ft_oe_n     out  held high (registered)
//   fifo_count  out  words buffered (registered)
//   words_sent  out  words accepted by the FT600, wraps (registered)
//   busy        out  transfer in progress or words buffered
// -----------------------------------------------------------------------------
module ft_tx_streamer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  ft_clk,
  input  logic                  rst,
  ft_tx_streamer_if.slave       s_if,
  input  logic                  ft_txe_n,
  output logic [15:0]           ft_data,
  output logic [1:0]            ft_be,
  output logic                  ft_data_oe,
  output logic                  ft_wr_n,
  output logic                  ft_rd_n,
  output logic                  ft_oe_n,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [CNT_W-1:0]      words_sent,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Full count is DEPTH, expressed at the counter width.
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [CNT_W-1:0]      SENT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // FIFO storage: {be, data} per entry.
  logic [17:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;

  state_t                state_q, state_d;
  logic [15:0]           data_q,  data_d;
  logic [1:0]            be_q,    be_d;
  logic                  oe_q,    oe_d;
  logic                  wr_n_q,  wr_n_d;
  logic                  rd_n_q;
  logic                  oe_n_q;
  logic [CNT_W-1:0]      sent_q,  sent_d;

  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_nonempty_s;
  logic [17:0]           head_s;

  // Full check uses the registered count only, so a pop in the same cycle
  // never opens room for a push while full.
  assign s_if.s_ready    = (count_q != CNT_FULL);
  assign push_s          = s_if.s_valid && (count_q != CNT_FULL);
  assign fifo_nonempty_s = (count_q != CNT_ZERO);
  assign head_s          = mem_q[rd_ptr_q];

  // FIFO storage write; storage is not reset, the pointers define validity.
  always_ff @(posedge ft_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {s_if.s_be, s_if.s_data};
    end
  end

  // FSM next state, pin next values and pop decision.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    be_d    = be_q;
    oe_d    = oe_q;
    wr_n_d  = wr_n_q;
    sent_d  = sent_q;
    pop_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wr_n_d = 1'b1;
        oe_d   = 1'b0;
        if (fifo_nonempty_s && !ft_txe_n) begin
          pop_s   = 1'b1;
          data_d  = head_s[15:0];
          be_d    = head_s[17:16];
          wr_n_d  = 1'b0;
          oe_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Strobe is low in this state, so txe low at the edge means the
        // presented word is taken by the FT600.
        if (!wr_n_q && !ft_txe_n) begin
          sent_d = sent_q + SENT_ONE;
          if (fifo_nonempty_s) begin
            pop_s   = 1'b1;
            data_d  = head_s[15:0];
            be_d    = head_s[17:16];
            wr_n_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = ST_WRITE;
          end else begin
            wr_n_d  = 1'b1;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          // Not taken: park the word on the pins with the strobe released.
          wr_n_d  = 1'b1;
          oe_d    = 1'b1;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        oe_d = 1'b1;
        if (!ft_txe_n) begin
          wr_n_d  = 1'b0;
          state_d = ST_WRITE;
        end else begin
          wr_n_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end

      default: begin
        wr_n_d  = 1'b1;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State, pin and counter registers with synchronous reset.
  always_ff @(posedge ft_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= 16'h0000;
      be_q     <= 2'b00;
      oe_q     <= 1'b0;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      sent_q   <= {CNT_W{1'b0}};
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      be_q     <= be_d;
      oe_q     <= oe_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign ft_data    = data_q;
  assign ft_be      = be_q;
  assign ft_data_oe = oe_q;
  assign ft_wr_n    = wr_n_q;
  assign ft_rd_n    = rd_n_q;
  assign ft_oe_n    = oe_n_q;
  assign fifo_count = count_q;
  assign words_sent = sent_q;
  assign busy       = (state_q != ST_IDLE) || fifo_nonempty_s;

endmodule
